// File: rtl/md_sched.sv
// md_sched: issue scheduler for the shared multiply/divide unit (X-ALU).
// It launches the X-ALU, counts down the busy window, signals completion,
// and drives the D-stage stall and the ID/EX bubble clear.
// Optional feature macro: MD_ABORT_EN. When it is defined, an interrupt
// during RUN aborts the operation. When it is undefined, the operation
// runs to completion.
module md_sched #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       md_start,
    input  logic [1:0] md_op,
    input  logic       md_use_D,
    input  logic       int_req,
    output logic       xalu_go,
    output logic [1:0] xalu_op,
    output logic       busy,
    output logic       stall,
    output logic       bubble_clr,
    output logic       md_done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // The counter starts at N-1, so the unit is busy for N cycles in total.
    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC - 1);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             xalu_go_q, xalu_go_d;
    logic [1:0]       xalu_op_q, xalu_op_d;
    logic             accept;
    logic             abort;

    // Issue acceptance, the abort qualifier and the pipeline control outputs.
    always_comb begin
        accept = md_start & ~int_req & (state_q == IDLE);
`ifdef MD_ABORT_EN
        abort  = int_req & (state_q == RUN);
`else
        abort  = 1'b0;
`endif
        busy       = (state_q == RUN);
        md_done    = busy & (cnt_q == '0) & ~abort;
        stall      = md_use_D & (busy | (md_start & ~int_req));
        bubble_clr = stall;
        xalu_go    = xalu_go_q;
        xalu_op    = xalu_op_q;
    end

    // Next-state logic: launch from IDLE, count down in RUN, then return to IDLE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        xalu_go_d = accept;
        xalu_op_d = xalu_op_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = RUN;
                    xalu_op_d = md_op;
                    cnt_d     = md_op[1] ? DIV_LD : MULT_LD;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            xalu_go_q <= 1'b0;
            xalu_op_q <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            xalu_go_q <= xalu_go_d;
            xalu_op_q <= xalu_op_d;
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed scenarios plus randomized traffic for md_sched.
// The reference model keeps a count of remaining busy cycles.
module tb_md_sched;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic       clk = 1'b0;
    logic       reset, md_start, md_use_D, int_req;
    logic [1:0] md_op;
    logic       xalu_go, busy, stall, bubble_clr, md_done;
    logic [1:0] xalu_op;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state.
    int         m_left  = 0;
    logic       m_go    = 1'b0;
    logic [1:0] m_op    = 2'b00;
    bit         m_valid = 1'b0;

    md_sched #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .md_start(md_start), .md_op(md_op),
        .md_use_D(md_use_D), .int_req(int_req), .xalu_go(xalu_go),
        .xalu_op(xalu_op), .busy(busy), .stall(stall),
        .bubble_clr(bubble_clr), .md_done(md_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check the DUT against the model, then
    // advance the model across the coming posedge.
    task automatic step(input logic s, input logic [1:0] op, input logic u,
                        input logic i, input logic r);
        bit   e_busy, e_done, e_stall, acc;
        @(negedge clk);
        md_start = s; md_op = op; md_use_D = u; int_req = i; reset = r;
        #1;
        e_busy  = (m_left > 0);
        e_done  = (m_left == 1);
`ifdef MD_ABORT_EN
        if (i) e_done = 1'b0;
`endif
        e_stall = u & (e_busy | (s & ~i));
        if (m_valid) begin
            check("busy", int'(busy), int'(e_busy));
            check("md_done", int'(md_done), int'(e_done));
            check("stall", int'(stall), int'(e_stall));
            check("bubble_clr", int'(bubble_clr), int'(e_stall));
            check("xalu_go", int'(xalu_go), int'(m_go));
            check("xalu_op", int'(xalu_op), int'(m_op));
        end
        acc = s & ~i & (m_left == 0);
        if (r) begin
            m_left = 0; m_go = 1'b0; m_op = 2'b00; m_valid = 1'b1;
        end else begin
            m_go = acc;
            if (acc) begin
                m_op   = op;
                m_left = op[1] ? DIV_N : MULT_N;
            end else if (m_left > 0) begin
`ifdef MD_ABORT_EN
                m_left = i ? 0 : m_left - 1;
`else
                m_left = m_left - 1;
`endif
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int nb, nd, ns, done_c, go_c;
        logic [1:0] go_op;
        reset = 1'b1; md_start = 1'b0; md_op = 2'b00; md_use_D = 1'b0; int_req = 1'b0;

        // Test 1: reset, then a mult is busy for 5 cycles.
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        check("reset_busy", int'(busy), 0);
        check("reset_go", int'(xalu_go), 0);
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        nb = 0; nd = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
            if (k == 0) check("t1_go", int'(xalu_go), 1);
            nb += int'(busy); nd += int'(md_done);
            if (k == 4) check("t1_done5", int'(md_done), 1);
            if (k == 5) check("t1_idle6", int'(busy), 0);
        end
        check("t1_busy_cnt", nb, MULT_N);
        check("t1_done_cnt", nd, 1);

        // Test 2: a div stalls D for exactly 10 cycles.
        step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        ns = 0;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
            ns += int'(stall);
        end
        check("t2_stall_cnt", ns, DIV_N);
        idle(1);

        // Test 3: an interrupt cancels the issue.
        step(1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
        check("t3_stall", int'(stall), 0);
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        check("t3_go", int'(xalu_go), 0);
        check("t3_busy", int'(busy), 0);

        // Test 4: a mult with int_req on its 3rd busy cycle.
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        nb = 0; nd = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 2'b00, 1'b0, (k == 2), 1'b0);
            nb += int'(busy); nd += int'(md_done);
        end
`ifdef MD_ABORT_EN
        check("t4_busy_cnt", nb, 3);
        check("t4_done_cnt", nd, 0);
`else
        check("t4_busy_cnt", nb, MULT_N);
        check("t4_done_cnt", nd, 1);
`endif

        // Test 5: back-to-back issue. The second xalu_go comes 2 cycles after md_done.
        step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        done_c = -1; go_c = -1; go_op = 2'b00;
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
            if (md_done && done_c < 0) done_c = k;
            if (xalu_go && k > 0 && go_c < 0) begin go_c = k; go_op = xalu_op; end
        end
        check("t5_go_gap", go_c - done_c, 2);
        check("t5_op", int'(go_op), 1);
        idle(8);

        // Test 6: reset on the 4th busy cycle of a div.
        step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        check("t6_busy", int'(busy), 0);
        check("t6_done", int'(md_done), 0);
        check("t6_go", int'(xalu_go), 0);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 99) < 40), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 8),
                 ($urandom_range(0, 999) < 5));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
